// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported memory between
// the instruction-fetch port and the load/store port; one transaction at a time.
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t                  state_q;
  owner_t                  owner_q;
  owner_t                  last_owner_q;
  logic [CW-1:0]           cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   if_rdata_q;
  logic [DATA_WIDTH-1:0]   d_rdata_q;
  logic                    if_valid_q;
  logic                    d_valid_q;

  logic                    issue_s;
  logic                    grant_data_s;
  logic [ADDR_WIDTH-1:0]   issue_addr_s;
  logic [DATA_WIDTH-1:0]   issue_wdata_s;
  logic                    issue_we_s;

  // Grant decision and winner's request fields for the issue cycle
  always_comb begin
    issue_s       = 1'b0;
    grant_data_s  = 1'b0;
    issue_addr_s  = if_addr;
    issue_wdata_s = '0;
    issue_we_s    = 1'b0;
    // Nothing is issued while reset is held, so no transaction is half-started.
    issue_s      = (state_q == S_IDLE) & (if_req | d_req) & ~rst;
    grant_data_s = d_req & (~if_req | (last_owner_q == OWN_FETCH));
    if (grant_data_s) begin
      issue_addr_s  = d_addr;
      issue_wdata_s = d_wdata;
      issue_we_s    = d_we;
    end else begin
      issue_addr_s  = if_addr;
      issue_wdata_s = '0;
      issue_we_s    = 1'b0;
    end
  end

  assign mem_en    = issue_s;
  assign mem_we    = issue_s & issue_we_s;
  assign mem_addr  = issue_s ? issue_addr_s : addr_q;
  assign mem_wdata = issue_s ? issue_wdata_s : wdata_q;

  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

  // Transaction FSM with latched request, latency counter and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_s) begin
            owner_q      <= grant_data_s ? OWN_DATA : OWN_FETCH;
            last_owner_q <= grant_data_s ? OWN_DATA : OWN_FETCH;
            addr_q       <= issue_addr_s;
            wdata_q      <= issue_wdata_s;
            we_q         <= issue_we_s;
            cnt_q        <= LAT_LOAD;
            state_q      <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            // Read data is valid this cycle; stores leave the rdata registers alone.
            if (!we_q) begin
              if (owner_q == OWN_DATA) begin
                d_rdata_q <= mem_rdata;
              end else begin
                if_rdata_q <= mem_rdata;
              end
            end
            if (owner_q == OWN_DATA) begin
              d_valid_q <= 1'b1;
            end else begin
              if_valid_q <= 1'b1;
            end
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, fixed-latency unified memory between the instruction-fetch port and the load/store port of the RISC-V core. One transaction at a time, round-robin on contention. Freezes the pipeline through `stall` until every pending request has completed. Sits between the PC/fetch logic, the memory-stage datapath, and the memory macro.

## Interface
- `DATA_WIDTH`, 32, width of data words.
- `ADDR_WIDTH`, 32, width of byte addresses.
- `MEM_LATENCY`, 2, number of cycles from the `mem_en` cycle to valid `mem_rdata`; must be ≥ 1.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req`  in  1  fetch request; level-held until `if_valid`.
- `if_addr`  in  ADDR_WIDTH  fetch address; stable while `if_req` is high.
- `if_rdata`  out  DATA_WIDTH  registered fetch data.
- `if_valid`  out  1  one-cycle fetch-completion pulse.
- `d_req`  in  1  data request; level-held until `d_valid`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_rdata`  out  DATA_WIDTH  registered load data.
- `d_valid`  out  1  one-cycle data-completion pulse.
- `stall`  out  1  pipeline freeze.
- `mem_en`  out  1  memory access strobe; one cycle per transaction.
- `mem_we`  out  1  memory write enable; valid only with `mem_en`.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid exactly `MEM_LATENCY` cycles after the `mem_en` cycle.

## Operation
- FSM states: IDLE, WAIT, DONE.
- Registers:
  - `owner`: FETCH or DATA.
  - `last_owner`: resets to FETCH.
  - Latched `addr`, `wdata` and `we`.
  - Latency counter, width clog2(`MEM_LATENCY`+1).
- **IDLE**, no request: stay in IDLE.
- **IDLE**, any request: issue in this cycle.
  - Grant rule: a single requester wins. If both request, the winner is the one that is not `last_owner`, so after reset DATA wins.
  - Drive `mem_en`=1 and drive `mem_addr` and `mem_wdata` combinationally from the winner.
  - `mem_we` = `d_we` for a DATA grant, 0 for a FETCH grant.
  - Latch `owner`, the address, the write data and `we`.
  - Set `last_owner` to the winner, load the counter with `MEM_LATENCY`, and go to WAIT.
- **WAIT**:
  - Counter decrements each cycle.
  - In the cycle where counter = 1, capture `mem_rdata` into the owner's rdata register, but only for reads. A DATA write leaves `d_rdata` unchanged.
  - Then go to DONE.
- **DONE**:
  - Assert the owner's valid for this cycle only.
  - Issue no transaction in this cycle, even if requests are present, because the completing requester still has `req` high.
  - Go to IDLE.
- Outside the issue cycle, `mem_en` and `mem_we` are 0, and `mem_addr`/`mem_wdata` show the latched values (reset value 0).
- `stall` = (`if_req` & ~`if_valid`) | (`d_req` & ~`d_valid`), combinational.
- Requester contract: after its valid pulse, a requester may drop `req` or present a new request at the clock edge that ends the pulse. The arbiter re-samples requests only in IDLE.

## Timing
- Reset values:
  - State IDLE, counter 0, `last_owner` FETCH.
  - `if_rdata`, `d_rdata`, latched address and latched write data all 0.
  - `if_valid`, `d_valid`, `mem_en`, `mem_we` all 0.
  - `stall` follows its equation; it is 0 when no request is present.
- Cycle sequence for a request first seen in IDLE at cycle N:
  - Issue at cycle N.
  - WAIT covers cycles N+1 … N+`MEM_LATENCY`.
  - Data is captured at the end of cycle N+`MEM_LATENCY`.
  - The valid pulse and DONE state are in cycle N+`MEM_LATENCY`+1.
  - IDLE again at N+`MEM_LATENCY`+2, which is the earliest next issue.
- Occupancy is `MEM_LATENCY`+2 cycles per transaction.
- Under continuous contention, grants alternate DATA, FETCH, DATA, and so on.
- A request arriving during WAIT or DONE waits for IDLE. `stall` stays high for it throughout.
- Reset in any state takes priority:
  - Return to reset values on the next edge.
  - The outstanding transaction is abandoned: no valid pulse, and its `mem_rdata` is ignored.
- With `MEM_LATENCY`=1, WAIT lasts exactly one cycle.

## Test plan
- **Reset:** hold `rst` for 2 cycles with both requests low → every output is at its reset value, `stall`=0, `mem_en`=0.
- **Fetch read, `MEM_LATENCY`=2:** stimulus is `if_req` with `if_addr`=0x10 at cycle 0, and the memory returns 0xDEADBEEF at cycle 2. Required response:
  - `mem_en`=1 and `mem_addr`=0x10 in cycle 0 only.
  - `if_valid`=1 in cycle 3 only, with `if_rdata`=0xDEADBEEF.
  - `stall`=1 in cycles 0–2 and 0 in cycle 3.
- **Contention after reset:** `if_req` and `d_req` both rise at cycle 0 → DATA issues at cycle 0 and `d_valid` at cycle 3; FETCH issues at cycle 4 and `if_valid` at cycle 7; continued contention keeps alternating.
- **Store:** `d_we`=1, `d_addr`=0x100, `d_wdata`=0x12345678 at cycle 0 → `mem_en`=1 and `mem_we`=1 with those values in cycle 0; `d_valid` at cycle 3; `d_rdata` keeps its previous value.
- **Reset mid-operation:** assert `rst` in cycle 1 of a fetch → no `if_valid` appears, state is IDLE, and a new `if_req` at cycle 3 issues at cycle 3 with correct data at cycle 6.
- **`MEM_LATENCY`=1 build:** fetch issued at cycle 0 → capture at the end of cycle 1, `if_valid` at cycle 2, next issue at cycle 3.
